// File: rtl/bomb_blast_controller.sv
// Per-bomb fuse/blast sequencer feeding the blue-blast drawer.
// It latches the blast window position and pattern when a bomb is placed, then runs frame-counted phases.
module bomb_blast_controller #(
   parameter int FUSE_FRAMES     = 120,
   parameter int BLAST_FRAMES    = 30,
   parameter int COOLDOWN_FRAMES = 15,
   parameter int FLASH_FRAMES    = 8,
   parameter int TILE_BITS       = 5
) (
   input  logic               clk,
   input  logic               resetN,
   input  logic               startOfFrame,
   input  logic               place_bomb,
   input  logic [4:0]         bombTileX,
   input  logic [3:0]         bombTileY,
   input  logic               wall_up,
   input  logic               wall_down,
   input  logic               wall_left,
   input  logic               wall_right,
   input  logic               detonate_now,
   output logic               ready,
   output logic               bomb_active,
   output logic               bomb_flash,
   output logic               blast,
   output logic               explode_pulse,
   output logic [2:0]         blast_num,
   output logic signed [10:0] topLeftX,
   output logic signed [10:0] topLeftY
);

   typedef enum logic [1:0] {IDLE, FUSE, BLAST, COOLDOWN} state_t;

   localparam logic [7:0] FUSE_LAST  = 8'(FUSE_FRAMES - 1);
   localparam logic [7:0] BLAST_LAST = 8'(BLAST_FRAMES - 1);
   localparam logic [7:0] COOL_LAST  = 8'(COOLDOWN_FRAMES - 1);
   localparam logic [7:0] FLASH_DIV  = 8'(FLASH_FRAMES);
   localparam logic [7:0] FLASH_LAST = 8'(FLASH_FRAMES - 1);
   // Window is 5x5 tiles centred on the bomb: two tiles (64 px) up/left.
   localparam logic [10:0] WIN_OFS   = 11'(2 << TILE_BITS);

   state_t      state, state_nxt;
   logic [7:0]  cnt, cnt_nxt, cnt_inc;
   logic        flash_nxt, pulse_nxt, latch;
   logic [2:0]  pattern;
   logic [10:0] px, py;

   assign cnt_inc = (cnt == 8'hFF) ? cnt : cnt + 8'd1;

   // Vertical-only wins when both neighbour pairs are walled.
   assign pattern = (wall_left & wall_right) ? 3'd1 :
                    (wall_up & wall_down)    ? 3'd2 : 3'd0;

   assign px = 11'(bombTileX) << TILE_BITS;
   assign py = 11'(bombTileY) << TILE_BITS;

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      flash_nxt = bomb_flash;
      pulse_nxt = 1'b0;
      latch     = 1'b0;
      case (state)
         IDLE: begin
            if (place_bomb) begin
               state_nxt = FUSE;
               cnt_nxt   = 8'd0;
               latch     = 1'b1;
            end
         end
         FUSE: begin
            // Chain detonation and natural expiry collapse into one transition.
            if (detonate_now || (startOfFrame && cnt == FUSE_LAST)) begin
               state_nxt = BLAST;
               cnt_nxt   = 8'd0;
               flash_nxt = 1'b0;
               pulse_nxt = 1'b1;
            end else if (startOfFrame) begin
               cnt_nxt = cnt_inc;
               if ((cnt % FLASH_DIV) == FLASH_LAST)
                  flash_nxt = ~bomb_flash;
            end
         end
         BLAST: begin
            if (startOfFrame) begin
               if (cnt == BLAST_LAST) begin
                  state_nxt = COOLDOWN;
                  cnt_nxt   = 8'd0;
               end else begin
                  cnt_nxt = cnt_inc;
               end
            end
         end
         COOLDOWN: begin
            if (startOfFrame) begin
               if (cnt == COOL_LAST) begin
                  state_nxt = IDLE;
                  cnt_nxt   = 8'd0;
               end else begin
                  cnt_nxt = cnt_inc;
               end
            end
         end
         default: begin
            state_nxt = IDLE;
            cnt_nxt   = 8'd0;
            flash_nxt = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         state         <= IDLE;
         cnt           <= 8'd0;
         ready         <= 1'b1;
         bomb_active   <= 1'b0;
         bomb_flash    <= 1'b0;
         blast         <= 1'b0;
         explode_pulse <= 1'b0;
         blast_num     <= 3'd0;
         topLeftX      <= 11'sd0;
         topLeftY      <= 11'sd0;
      end else begin
         state         <= state_nxt;
         cnt           <= cnt_nxt;
         ready         <= (state_nxt == IDLE);
         bomb_active   <= (state_nxt == FUSE);
         blast         <= (state_nxt == BLAST);
         bomb_flash    <= flash_nxt;
         explode_pulse <= pulse_nxt;
         if (latch) begin
            blast_num <= pattern;
            topLeftX  <= $signed(px - WIN_OFS);
            topLeftY  <= $signed(py - WIN_OFS);
         end
      end
   end

endmodule

// File: tb/tb_bomb_blast_controller.sv
// Directed + randomized bench for bomb_blast_controller against a frame-level reference model.
module tb_bomb_blast_controller;

   localparam int FUSE_F  = 4;
   localparam int BLAST_F = 2;
   localparam int COOL_F  = 1;
   localparam int FLASH_F = 2;

   logic        clk, resetN, startOfFrame, place_bomb, detonate_now;
   logic [4:0]  bombTileX;
   logic [3:0]  bombTileY;
   logic        wall_up, wall_down, wall_left, wall_right;
   logic        ready, bomb_active, bomb_flash, blast, explode_pulse;
   logic [2:0]  blast_num;
   logic [10:0] topLeftX, topLeftY;

   int checks = 0;
   int errors = 0;

   bomb_blast_controller #(
      .FUSE_FRAMES(FUSE_F), .BLAST_FRAMES(BLAST_F), .COOLDOWN_FRAMES(COOL_F),
      .FLASH_FRAMES(FLASH_F), .TILE_BITS(5)
   ) dut (
      .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame), .place_bomb(place_bomb),
      .bombTileX(bombTileX), .bombTileY(bombTileY),
      .wall_up(wall_up), .wall_down(wall_down), .wall_left(wall_left), .wall_right(wall_right),
      .detonate_now(detonate_now), .ready(ready), .bomb_active(bomb_active),
      .bomb_flash(bomb_flash), .blast(blast), .explode_pulse(explode_pulse),
      .blast_num(blast_num), .topLeftX(topLeftX), .topLeftY(topLeftY)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: phase 0 idle, 1 fuse, 2 blast, 3 cooldown; frames seen in phase.
   int          m_ph, m_frames;
   bit          m_flash, m_pulse;
   logic [2:0]  m_num;
   logic [10:0] m_tx, m_ty;

   task automatic model_reset();
      m_ph = 0; m_frames = 0; m_flash = 0; m_pulse = 0;
      m_num = 3'd0; m_tx = 11'd0; m_ty = 11'd0;
   endtask

   task automatic model_edge();
      if (!resetN) begin
         model_reset();
         return;
      end
      m_pulse = 0;
      case (m_ph)
         0: if (place_bomb) begin
               m_ph = 1; m_frames = 0;
               m_tx = 11'(int'(bombTileX) * 32 - 64);
               m_ty = 11'(int'(bombTileY) * 32 - 64);
               if (wall_left && wall_right)   m_num = 3'd1;
               else if (wall_up && wall_down) m_num = 3'd2;
               else                           m_num = 3'd0;
            end
         1: if (detonate_now || (startOfFrame && m_frames == FUSE_F - 1)) begin
               m_ph = 2; m_frames = 0; m_flash = 0; m_pulse = 1;
            end else if (startOfFrame) begin
               if (m_frames % FLASH_F == FLASH_F - 1) m_flash = !m_flash;
               m_frames = (m_frames < 255) ? m_frames + 1 : 255;
            end
         2: if (startOfFrame) begin
               if (m_frames == BLAST_F - 1) begin m_ph = 3; m_frames = 0; end
               else m_frames++;
            end
         default: if (startOfFrame) begin
               if (m_frames == COOL_F - 1) begin m_ph = 0; m_frames = 0; end
               else m_frames++;
            end
      endcase
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic compare_all();
      chk("ready",         32'(ready),         32'(m_ph == 0));
      chk("bomb_active",   32'(bomb_active),   32'(m_ph == 1));
      chk("blast",         32'(blast),         32'(m_ph == 2));
      chk("bomb_flash",    32'(bomb_flash),    32'(m_flash));
      chk("explode_pulse", 32'(explode_pulse), 32'(m_pulse));
      chk("blast_num",     32'(blast_num),     32'(m_num));
      chk("topLeftX",      32'(topLeftX),      32'(m_tx));
      chk("topLeftY",      32'(topLeftY),      32'(m_ty));
   endtask

   task automatic step(input bit sof);
      startOfFrame = sof;
      model_edge();
      @(posedge clk); #1;
      compare_all();
      startOfFrame = 1'b0;
   endtask

   task automatic place(input int x, input int y, input logic [3:0] walls);
      bombTileX = 5'(x); bombTileY = 4'(y);
      {wall_up, wall_down, wall_left, wall_right} = walls;
      place_bomb = 1'b1;
      step(1'b0);
      place_bomb = 1'b0;
      {wall_up, wall_down, wall_left, wall_right} = 4'(~walls);
   endtask

   task automatic to_idle(input string tag);
      for (int k = 0; k < 200 && m_ph != 0; k++) step(k % 3 == 0);
      chk(tag, 32'(ready), 32'd1);
   endtask

   initial begin
      resetN = 1'b0; startOfFrame = 1'b0; place_bomb = 1'b0; detonate_now = 1'b0;
      bombTileX = '0; bombTileY = '0;
      {wall_up, wall_down, wall_left, wall_right} = 4'b0;
      model_reset();

      // Reset, then idle with no stimulus
      for (int k = 0; k < 3; k++) step(1'b0);
      resetN = 1'b1;
      for (int k = 0; k < 6; k++) step(k % 2 == 0);
      chk("idle_tlx", 32'(topLeftX), 32'd0);

      // Nominal bomb at (5,3)
      place(5, 3, 4'b0000);
      chk("nom_tlx", 32'(topLeftX), 32'd96);
      chk("nom_tly", 32'(topLeftY), 32'd32);
      chk("nom_num", 32'(blast_num), 32'd0);
      for (int f = 0; f < 3; f++) begin step(1'b1); step(1'b0); step(1'b0); end
      chk("nom_no_blast_yet", 32'(blast), 32'd0);
      step(1'b1);
      chk("nom_pulse", 32'(explode_pulse), 32'd1);
      chk("nom_blast_on", 32'(blast), 32'd1);
      step(1'b0);
      chk("nom_pulse_once", 32'(explode_pulse), 32'd0);
      step(1'b1); step(1'b0);
      chk("nom_blast_hold", 32'(blast), 32'd1);
      step(1'b1);
      chk("nom_blast_off", 32'(blast), 32'd0);
      chk("nom_cool_notready", 32'(ready), 32'd0);
      step(1'b0); step(1'b1);
      chk("nom_ready_back", 32'(ready), 32'd1);

      // Wall patterns
      place(7, 7, 4'b0011); chk("wall_lr", 32'(blast_num), 32'd1); to_idle("wall_lr_idle");
      place(8, 6, 4'b1100); chk("wall_ud", 32'(blast_num), 32'd2); to_idle("wall_ud_idle");
      place(9, 5, 4'b1111); chk("wall_all", 32'(blast_num), 32'd1); to_idle("wall_all_idle");

      // Edge tile
      place(0, 0, 4'b0000);
      chk("edge_tlx", 32'(topLeftX), 32'h7C0);
      chk("edge_tly", 32'(topLeftY), 32'h7C0);
      to_idle("edge_idle");

      // Chain reaction in the 2nd fuse frame, then place_bomb during BLAST
      place(10, 5, 4'b0000);
      step(1'b1); step(1'b0);
      detonate_now = 1'b1; step(1'b0); detonate_now = 1'b0;
      chk("det_blast", 32'(blast), 32'd1);
      chk("det_pulse", 32'(explode_pulse), 32'd1);
      for (int k = 0; k < 20 && m_ph == 2; k++) begin
         place_bomb = 1'b1;
         step(k % 2 == 1);
         chk("blast_place_ignored", 32'(ready), 32'd0);
      end
      place_bomb = 1'b0;
      to_idle("det_idle");
      step(1'b0);
      chk("place_not_queued", 32'(bomb_active), 32'd0);

      // Detonation coincident with the final fuse frame
      place(2, 2, 4'b0000);
      for (int f = 0; f < 3; f++) begin step(1'b1); step(1'b0); end
      detonate_now = 1'b1;
      step(1'b1);
      chk("coin_pulse", 32'(explode_pulse), 32'd1);
      step(1'b0);
      chk("coin_single", 32'(explode_pulse), 32'd0);
      detonate_now = 1'b0;
      to_idle("coin_idle");

      // Reset mid-fuse
      place(4, 4, 4'b0000);
      step(1'b1); step(1'b0);
      #2 resetN = 1'b0;
      #1;
      chk("rst_ready", 32'(ready), 32'd1);
      chk("rst_active", 32'(bomb_active), 32'd0);
      chk("rst_tlx", 32'(topLeftX), 32'd0);
      model_reset();
      step(1'b0); step(1'b0);
      resetN = 1'b1;
      for (int k = 0; k < 30; k++) begin
         step(k % 2 == 0);
         chk("rst_no_blast", 32'(blast | explode_pulse), 32'd0);
      end

      // Randomized traffic
      for (int k = 0; k < 3000; k++) begin
         resetN       = ($urandom_range(0, 499) != 0);
         place_bomb   = ($urandom_range(0, 7) == 0);
         detonate_now = ($urandom_range(0, 39) == 0);
         bombTileX    = 5'($urandom_range(0, 19));
         bombTileY    = 4'($urandom_range(0, 14));
         {wall_up, wall_down, wall_left, wall_right} = 4'($urandom);
         step($urandom_range(0, 2) == 0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/bomb_blast_controller.md
Name: bomb_blast_controller

Overview:
- Per-bomb timing and placement controller sitting directly upstream of the blue-blast bitmap drawer.
- Accepts a bomb placement, runs a frame-counted fuse, then asserts `blast` for a fixed number of frames.
- Supplies the drawer with a stable pattern index `blast_num` and the signed top-left pixel position of the 5x5-tile blast window; that position feeds the square-object stage that produces the drawer's offsets and InsideRectangle.

Parameters:
- FUSE_FRAMES, 120, frames from placement to explosion (min 2)
- BLAST_FRAMES, 30, frames `blast` stays high (min 1)
- COOLDOWN_FRAMES, 15, frames after blast before a new bomb is accepted (min 1)
- FLASH_FRAMES, 8, bomb_flash toggle period in frames during fuse
- TILE_BITS, 5, log2 of tile size in pixels (32)

Ports:
- clk  in  1  system clock
- resetN  in  1  asynchronous active-low reset
- startOfFrame  in  1  one-cycle pulse per video frame
- place_bomb  in  1  request to place a bomb (level or pulse, sampled in IDLE only)
- bombTileX  in  5  tile column 0..19 of the bomb
- bombTileY  in  4  tile row 0..14 of the bomb
- wall_up, wall_down, wall_left, wall_right  in  1 each  neighbour tile is an indestructible wall
- detonate_now  in  1  chain-reaction request; forces early explosion
- ready  out  1  high in IDLE only
- bomb_active  out  1  high during FUSE
- bomb_flash  out  1  fuse blink bit
- blast  out  1  high during BLAST
- explode_pulse  out  1  one-cycle pulse on FUSE->BLAST entry
- blast_num  out  3  pattern index: 0 cross, 1 vertical, 2 horizontal
- topLeftX  out  11  signed two's complement, blast window left pixel
- topLeftY  out  11  signed two's complement, blast window top pixel

Behaviour:
- Interface: one clock, clk; reset is asynchronous and active-low, resetN.
- Reset values: state=IDLE, ready=1, bomb_active=0, bomb_flash=0, blast=0, explode_pulse=0, blast_num=0, topLeftX=0, topLeftY=0, frame counter=0.
- All outputs are registered.
- Reset asserted mid-operation aborts immediately to the reset values; no explosion is emitted.

State machine: IDLE, FUSE, BLAST, COOLDOWN.
- IDLE:
  - On a clock edge with place_bomb=1, move to FUSE next cycle and clear the counter.
  - On that same edge, latch topLeftX=(bombTileX<<TILE_BITS)-64 and topLeftY=(bombTileY<<TILE_BITS)-64 as 11-bit signed values. Negative results at the left/top edge are legal.
  - On that same edge, latch blast_num:
    - 1 if wall_left & wall_right.
    - else 2 if wall_up & wall_down.
    - else 0.
    - If both pairs are walled, the result is 1 (vertical has priority).
  - blast_num, topLeftX and topLeftY are held constant from then until the next accepted placement. The drawer samples blast_num while blast=0, so it is valid at least one cycle before blast rises.
- FUSE: bomb_active=1.
  - Counter increments on each startOfFrame.
  - bomb_flash toggles when the counter value mod FLASH_FRAMES == FLASH_FRAMES-1 at a startOfFrame.
  - Transition to BLAST occurs on whichever comes first:
    - a startOfFrame with counter==FUSE_FRAMES-1;
    - detonate_now=1 on any edge.
  - If both occur on the same edge, only one transition and one explode_pulse are produced.
- BLAST entry: explode_pulse=1 for exactly one cycle; blast=1; bomb_active=0; bomb_flash=0; counter cleared.
- BLAST: leaves on the startOfFrame where counter==BLAST_FRAMES-1. blast=0 from the next cycle. detonate_now is ignored.
- COOLDOWN: counts COOLDOWN_FRAMES startOfFrame pulses, then goes to IDLE; ready=1 the next cycle.
- place_bomb outside IDLE is ignored and not queued.
- Counter is 8 bits and saturates; it never wraps.
- The first startOfFrame counted is the first one strictly after state entry.

Test Plan:
- Reset then idle: resetN low for 3 cycles, then release with no stimulus -> ready=1, blast=0, blast_num=0, topLeftX=0, topLeftY=0 throughout.
- Nominal bomb:
  - Setup: FUSE_FRAMES=4, BLAST_FRAMES=2, COOLDOWN_FRAMES=1.
  - Stimulus: place at tile (5,3), no walls.
  - Expected: topLeftX=96, topLeftY=32, blast_num=0. explode_pulse occurs one cycle after the 4th startOfFrame; blast lasts 2 frames; ready returns after 1 further frame.
- Wall patterns:
  - wall_left=wall_right=1 -> blast_num=1.
  - wall_up=wall_down=1 -> blast_num=2.
  - All four walls -> blast_num=1.
  - In each case the value is stable from the cycle after placement through the end of BLAST.
- Edge tile: place at (0,0) -> topLeftX=topLeftY=11'h7C0 (-64).
- Chain reaction and collisions:
  - detonate_now during the 2nd fuse frame -> BLAST the next cycle, a single explode_pulse.
  - detonate_now coincident with the final fuse startOfFrame -> exactly one pulse.
  - place_bomb during BLAST -> ignored; ready stays 0.
- Reset mid-fuse: resetN low during FUSE -> immediate IDLE reset values; no blast or explode_pulse occurs afterwards without a new placement.
